// File: rtl/nanop_pkg.sv
// nanop_pkg: definitions shared across the nanoprocessor blocks.
//   - Opcode encodings of the 4-bit instruction field.
//   - out_state_t: states of the OUT-port display FSM.
package nanop_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } out_state_t;

endpackage

// File: rtl/nanop_out_port_if.sv
// nanop_out_port_if: bus between the CPU core / board and the OUT port.
//   out_valid, out_data, clear : driven by the master (core side)
//   leds, busy, full,
//   fifo_count, overflow       : driven by the slave (the OUT port)
interface nanop_out_port_if #(
  parameter int DEPTH = 4
);
  logic                       out_valid;
  logic [7:0]                 out_data;
  logic                       clear;
  logic [7:0]                 leds;
  logic                       busy;
  logic                       full;
  logic [$clog2(DEPTH):0]     fifo_count;
  logic                       overflow;

  modport master (
    output out_valid, out_data, clear,
    input  leds, busy, full, fifo_count, overflow
  );

  modport slave (
    input  out_valid, out_data, clear,
    output leds, busy, full, fifo_count, overflow
  );
endinterface

// File: rtl/nanop_out_fifo.sv
// nanop_out_fifo: DEPTH x WIDTH synchronous FIFO.
//   clk, reset  : clock and synchronous active-high reset
//   clear       : synchronous flush (same effect as reset)
//   push/push_data : write at tail, ignored when full
//   pop         : remove head, ignored when empty
//   head        : current head entry (valid while !empty)
//   count/full/empty : occupancy, all derived from the registered count
module nanop_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  // full/empty come from the registered count, so a push while full is
  // dropped even when a pop frees a slot on the same edge.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; pointers define which entries are live.
  // A flush also blocks the write so a same-cycle value cannot reappear.
  always_ff @(posedge clk) begin
    if (push_ok && !reset && !clear) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/nanop_out_port.sv
// nanop_out_port: receiving end of the nanoprocessor OUT instruction.
// Each OUT value is queued and shown on the LEDs for HOLD_CYCLES cycles.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of nanop_out_port_if
//                (out_valid/out_data/clear in; leds/busy/full/
//                 fifo_count/overflow out)
module nanop_out_port
  import nanop_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  nanop_out_port_if.slave         bus
);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  out_state_t       state_q, state_d;
  logic [HW-1:0]    counter_q, counter_d;
  logic [7:0]       leds_q, leds_d;
  logic             overflow_q, overflow_d;
  logic             pop;
  logic [7:0]       head;
  logic             full, empty;
  logic [$clog2(DEPTH):0] count;

  nanop_out_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.clear),
    .push      (bus.out_valid),
    .push_data (bus.out_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // State register, hold counter, displayed value and sticky flag.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      leds_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      leds_q     <= leds_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic. Reloading straight from SHOW avoids a blank cycle
  // between queued values, so each value is held exactly HOLD_CYCLES.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    leds_d    = leds_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          leds_d    = head;
          counter_d = HOLD_LOAD;
          state_d   = SHOW;
        end
      end
      SHOW: begin
        if (counter_q != '0) begin
          counter_d = counter_q - HW'(1);
        end else if (!empty) begin
          pop       = 1'b1;
          leds_d    = head;
          counter_d = HOLD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    overflow_d = overflow_q | (bus.out_valid & full);
  end

  // Outputs.
  always_comb begin
    bus.leds       = leds_q;
    bus.busy       = (state_q == SHOW);
    bus.full       = full;
    bus.fifo_count = count;
    bus.overflow   = overflow_q;
  end

endmodule

// File: tb/tb_nanop_out_port.sv
// tb_nanop_out_port: directed, table-driven bench for nanop_out_port with
// DEPTH=4, HOLD_CYCLES=4. Inputs change on the falling edge, outputs are
// sampled 1 time unit after each rising edge.
module tb_nanop_out_port;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  nanop_out_port_if #(.DEPTH(4)) bus ();

  nanop_out_port #(
    .DEPTH       (4),
    .HOLD_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] leds;
    logic       busy;
    logic [2:0] cnt;
    logic       full;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic [7:0] leds,
                     input logic busy, input logic [2:0] cnt, input logic full,
                     input logic ovf);
    vec_t r;
    r.v = v; r.d = d; r.leds = leds; r.busy = busy;
    r.cnt = cnt; r.full = full; r.ovf = ovf;
    tbl.push_back(r);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic c,
                      input logic r);
    @(negedge clk);
    bus.out_valid = v;
    bus.out_data  = d;
    bus.clear     = c;
    reset         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] leds,
                            input logic busy, input logic [2:0] cnt,
                            input logic full, input logic ovf);
    chk({tag, ".leds"},       int'(bus.leds),       int'(leds));
    chk({tag, ".busy"},       int'(bus.busy),       int'(busy));
    chk({tag, ".fifo_count"}, int'(bus.fifo_count), int'(cnt));
    chk({tag, ".full"},       int'(bus.full),       int'(full));
    chk({tag, ".overflow"},   int'(bus.overflow),   int'(ovf));
    $display("%s: in v=%0b d=%02h -> leds=%02h busy=%0b cnt=%0d full=%0b ovf=%0b",
             tag, bus.out_valid, bus.out_data, bus.leds, bus.busy,
             bus.fifo_count, bus.full, bus.overflow);
  endtask

  initial begin
    // Single write of 0xA5 from an idle, empty port.
    add(1, 8'hA5, 8'h00, 0, 1, 0, 0);
    add(0, 8'h00, 8'hA5, 1, 0, 0, 0);
    add(0, 8'h00, 8'hA5, 1, 0, 0, 0);
    add(0, 8'h00, 8'hA5, 1, 0, 0, 0);
    add(0, 8'h00, 8'hA5, 1, 0, 0, 0);
    add(0, 8'h00, 8'hA5, 0, 0, 0, 0);
    add(0, 8'h00, 8'hA5, 0, 0, 0, 0);
    // Back-to-back 0x01, 0x02, 0x03.
    add(1, 8'h01, 8'hA5, 0, 1, 0, 0);
    add(1, 8'h02, 8'h01, 1, 1, 0, 0);
    add(1, 8'h03, 8'h01, 1, 2, 0, 0);
    add(0, 8'h00, 8'h01, 1, 2, 0, 0);
    add(0, 8'h00, 8'h01, 1, 2, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 8'h00, 8'h02, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 8'h00, 8'h03, 1, 0, 0, 0);
    add(0, 8'h00, 8'h03, 0, 0, 0, 0);
    add(0, 8'h00, 8'h03, 0, 0, 0, 0);
    // Overflow: 0x10..0x15, 0x15 dropped while full.
    add(1, 8'h10, 8'h03, 0, 1, 0, 0);
    add(1, 8'h11, 8'h10, 1, 1, 0, 0);
    add(1, 8'h12, 8'h10, 1, 2, 0, 0);
    add(1, 8'h13, 8'h10, 1, 3, 0, 0);
    add(1, 8'h14, 8'h10, 1, 4, 1, 0);
    add(1, 8'h15, 8'h11, 1, 3, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 8'h00, 8'h11, 1, 3, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 8'h00, 8'h12, 1, 2, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 8'h00, 8'h13, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 8'h00, 8'h14, 1, 0, 0, 1);
    add(0, 8'h00, 8'h14, 0, 0, 0, 1);
    add(0, 8'h00, 8'h14, 0, 0, 0, 1);

    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    bus.clear     = 1'b0;
    reset         = 1'b1;

    // Reset held for two cycles.
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    check_outs("reset", 8'h00, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, 0, 0);
      check_outs($sformatf("vec%0d", i), tbl[i].leds, tbl[i].busy,
                 tbl[i].cnt, tbl[i].full, tbl[i].ovf);
    end

    // Clear mid-hold with a simultaneous write; overflow is still sticky.
    step(1, 8'h20, 0, 0);
    step(1, 8'h21, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h23, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    check_outs("clr_setup", 8'h21, 1, 2, 0, 1);
    step(1, 8'h77, 1, 0);
    check_outs("clr_edge", 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 8'h00, 0, 0);
      check_outs($sformatf("clr_after%0d", i), 8'h00, 0, 0, 0, 0);
    end

    // Reset mid-operation, then a fresh write of 0x3C.
    step(1, 8'h20, 0, 0);
    step(1, 8'h21, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h23, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    check_outs("rst_setup", 8'h21, 1, 2, 0, 0);
    step(1, 8'h55, 0, 1);
    check_outs("rst_edge", 8'h00, 0, 0, 0, 0);
    step(1, 8'h3C, 0, 0);
    check_outs("rst_wr", 8'h00, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 0, 0);
      check_outs($sformatf("rst_show%0d", i), 8'h3C, 1, 0, 0, 0);
    end
    step(0, 8'h00, 0, 0);
    check_outs("rst_done", 8'h3C, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
